or1200_cypherdb_marker_detect: RTL and testbench
================================================

Name: or1200_cypherdb_marker_detect

Overview:
- Upstream feeder of the secure-execution window tracker.
- Watches the EX-stage instruction stream and detects committed CypherDB marker instructions (l.nop with reserved immediates).
- Produces the single-cycle start/end pulses that the window tracker stretches into secure_exec.
- Also counts instructions executed inside the window, flags protocol errors, and optionally enforces a maximum window length.

Parameters:
- START_K, 16'h00D0, l.nop immediate that marks region entry
- END_K, 16'h00D1, l.nop immediate that marks region exit
- CNT_W, 16, width of the in-region instruction counter
- MAX_INSN, 16'hFFFF, watchdog limit in committed instructions; used only when the optional feature is compiled in

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ce  in  1  CypherDB enable; low forces idle
- ex_insn  in  32  instruction in EX stage
- ex_valid  in  1  EX instruction is valid (not a bubble)
- ex_freeze  in  1  EX stage frozen; the instruction does not commit this cycle
- ex_flush  in  1  exception/branch flush; kills the EX instruction
- start_pulse  out  1  one-cycle pulse on region entry
- end_pulse  out  1  one-cycle pulse on region exit
- in_region  out  1  shadow of region state, for debug and SPR readback
- region_len  out  CNT_W  instruction count of the last completed region
- marker_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0. Reset is asynchronous and active-high (posedge rst in the sensitivity list).
- commit = ex_valid & ~ex_freeze & ~ex_flush.
- is_start = (ex_insn[31:24]==8'h15) & (ex_insn[15:0]==START_K). is_end is the same with END_K. Only bits [31:24] and [15:0] are compared.
- All outputs are registered. For a marker committing on rising edge N, the pulse is high during cycle N+1 for exactly one cycle.
- FSM states are IDLE and ACTIVE.
  - IDLE, commit & is_start: go to ACTIVE, assert start_pulse, clear counter.
  - IDLE, commit & is_end: stay in IDLE, assert marker_err.
  - ACTIVE, commit & is_end: go to IDLE, assert end_pulse, load region_len with counter.
  - ACTIVE, commit & is_start: this is nesting and is forbidden. Stay in ACTIVE, assert marker_err, do not touch the counter.
  - ACTIVE, any other commit: counter += 1, saturating at all-ones. The markers themselves are not counted.
- Frozen or flushed markers have no effect, even if they are held in EX for many cycles.
- A marker that is frozen for several cycles and then commits produces exactly one pulse.
- in_region = (state==ACTIVE).
- ce low: state goes to IDLE and the counter clears. No pulses are generated, and region_len holds its value. This matches the downstream tracker, which also drops on ce low.
- ce high-to-low while ACTIVE: end_pulse is not generated.
- start_pulse and end_pulse are never high in the same cycle.
- Reset mid-region: the block returns to IDLE immediately and asynchronously, with no pulses.

Optional Feature:
- Macro: OR1200_CYPHERDB_MARKER_WATCHDOG_EN.
- Defined: in ACTIVE, when the counter reaches MAX_INSN on a commit, the block forces end_pulse and marker_err in the same cycle, loads region_len=MAX_INSN, and goes to IDLE.
  - If a real end marker commits on that same edge, the end marker wins: end_pulse is asserted and marker_err is not.
- Undefined: no watchdog logic. The counter simply saturates, and the MAX_INSN parameter is unused.

Decomposition:
- Shared include or1200_cypherdb_defines.v holds:
  - state encodings CDB_MD_IDLE/CDB_MD_ACTIVE
  - the l.nop opcode constant 8'h15
  - default START_K/END_K
- One sub-module, or1200_cypherdb_insn_cnt: the saturating, clearable counter with a terminal-count flag. It is reused later for SPR counters.

Test Plan:
- Basic: commit 0x150000D0, then 5 ordinary instructions, then commit 0x150000D1.
  - start_pulse 1 cycle after the start commit; end_pulse 1 cycle after the end commit.
  - region_len=5; in_region high between the two pulses.
- Freeze: hold 0x150000D0 in EX with ex_freeze=1 for 4 cycles, then release.
  - Exactly one start_pulse, one cycle after release.
- Flush: 0x150000D0 with ex_flush=1.
  - No start_pulse, in_region stays 0.
  - Then 0x150000D1 in IDLE gives a marker_err pulse and no end_pulse.
- Nesting: inside a region, commit 0x150000D0 again.
  - marker_err pulse, in_region stays 1, counter unchanged.
  - A subsequent end marker gives a normal end_pulse.
- ce and reset: in ACTIVE, drop ce for 1 cycle.
  - in_region goes 0, no end_pulse.
  - Repeat the scenario with rst asserted mid-region: outputs go 0 asynchronously.
- Watchdog (feature on): MAX_INSN=8, start marker, then 8 ordinary instructions.
  - end_pulse and marker_err together, region_len=8.
  - With the macro undefined, the same stimulus stays ACTIVE.

Source files
------------

// File: rtl/or1200_cypherdb_marker_detect_pkg.sv
// ----------------------------------------------------------------------------
// or1200_cypherdb_marker_detect_pkg
//
// Shared definitions for the CypherDB marker detector and its helpers:
//   - FSM state encodings CDB_MD_IDLE / CDB_MD_ACTIVE
//   - the l.nop major opcode (bits [31:24])
//   - default l.nop immediates for region entry / exit markers
//   - isMarker(): compares only opcode [31:24] and immediate [15:0]
// ----------------------------------------------------------------------------
package or1200_cypherdb_marker_detect_pkg;

  typedef enum logic {
    CDB_MD_IDLE   = 1'b0,
    CDB_MD_ACTIVE = 1'b1
  } cdb_md_state_e;

  localparam logic [7:0]  CDB_LNOP_OPC    = 8'h15;
  localparam logic [15:0] CDB_START_K_DEF = 16'h00D0;
  localparam logic [15:0] CDB_END_K_DEF   = 16'h00D1;

  // Bits [23:16] of an l.nop are don't-care for marker matching.
  function automatic logic isMarker(input logic [31:0] insn, input logic [15:0] imm);
    return (insn[31:24] == CDB_LNOP_OPC) && (insn[15:0] == imm);
  endfunction

endpackage

// File: rtl/or1200_cypherdb_insn_cnt.sv
// ----------------------------------------------------------------------------
// or1200_cypherdb_insn_cnt
//
// Saturating, synchronously clearable up-counter with a terminal-count flag.
// Used for the in-region instruction count and intended for SPR counters.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high reset (count -> 0)
//   clr_i   in   synchronous clear, has priority over inc_i
//   inc_i   in   increment request; ignored once the count is all-ones
//   cnt_o   out  current count
//   tc_o    out  terminal count: count is saturated at all-ones
// ----------------------------------------------------------------------------
module or1200_cypherdb_insn_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = &cnt_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/or1200_cypherdb_marker_detect.sv
// ----------------------------------------------------------------------------
// or1200_cypherdb_marker_detect
//
// Watches the EX-stage instruction stream for committed CypherDB marker
// l.nops and produces registered one-cycle start/end pulses for the secure
// window tracker. Counts non-marker instructions committed inside a region
// and reports protocol violations (end outside a region, nested start).
//
// Optional build macro: OR1200_CYPHERDB_MARKER_WATCHDOG_EN
//   When defined, a region is force-closed (end_pulse_o + marker_err_o) once
//   MAX_INSN instructions have committed inside it. The MAX_INSN parameter
//   exists only in that build.
//
// Ports:
//   clk_i         in   clock
//   rst_i         in   asynchronous active-high reset
//   ce_i          in   CypherDB enable; low forces idle, clears the counter
//   ex_insn_i     in   EX-stage instruction
//   ex_valid_i    in   EX instruction valid
//   ex_freeze_i   in   EX frozen, no commit this cycle
//   ex_flush_i    in   EX instruction killed
//   start_pulse_o out  one-cycle pulse on region entry
//   end_pulse_o   out  one-cycle pulse on region exit
//   in_region_o   out  region state shadow
//   region_len_o  out  instruction count of the last completed region
//   marker_err_o  out  one-cycle pulse on a protocol violation
// ----------------------------------------------------------------------------
module or1200_cypherdb_marker_detect
  import or1200_cypherdb_marker_detect_pkg::*;
#(
  parameter logic [15:0]      START_K  = CDB_START_K_DEF,
  parameter logic [15:0]      END_K    = CDB_END_K_DEF,
`ifdef OR1200_CYPHERDB_MARKER_WATCHDOG_EN
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_INSN = CNT_W'(16'hFFFF)
`else
  parameter int unsigned      CNT_W    = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [31:0]      ex_insn_i,
  input  logic             ex_valid_i,
  input  logic             ex_freeze_i,
  input  logic             ex_flush_i,
  output logic             start_pulse_o,
  output logic             end_pulse_o,
  output logic             in_region_o,
  output logic [CNT_W-1:0] region_len_o,
  output logic             marker_err_o
);

`ifdef OR1200_CYPHERDB_MARKER_WATCHDOG_EN
  // The watchdog fires on the commit that takes the count to MAX_INSN.
  localparam logic [CNT_W-1:0] WdPreLimit = MAX_INSN - 1'b1;
`endif

  cdb_md_state_e    state_q, state_d;
  logic             startPulse_q, startPulse_d;
  logic             endPulse_q, endPulse_d;
  logic             markerErr_q, markerErr_d;
  logic [CNT_W-1:0] regionLen_q, regionLen_d;

  logic             commit, isStart, isEnd;
  logic             cntClr, cntInc, cntTc;
  logic [CNT_W-1:0] cntValue;

  assign commit  = ex_valid_i & ~ex_freeze_i & ~ex_flush_i;
  assign isStart = isMarker(ex_insn_i, START_K);
  assign isEnd   = isMarker(ex_insn_i, END_K);

  or1200_cypherdb_insn_cnt #(
    .W(CNT_W)
  ) u_insn_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cntClr),
    .inc_i (cntInc),
    .cnt_o (cntValue),
    .tc_o  (cntTc)
  );

  always_comb begin
    state_d      = state_q;
    startPulse_d = 1'b0;
    endPulse_d   = 1'b0;
    markerErr_d  = 1'b0;
    regionLen_d  = regionLen_q;
    cntClr       = 1'b0;
    cntInc       = 1'b0;

    // Disabling drops the region silently; region_len keeps the last result.
    if (!ce_i) begin
      state_d = CDB_MD_IDLE;
      cntClr  = 1'b1;
    end else if (commit) begin
      unique case (state_q)
        CDB_MD_IDLE: begin
          if (isStart) begin
            state_d      = CDB_MD_ACTIVE;
            startPulse_d = 1'b1;
            cntClr       = 1'b1;
          end else if (isEnd) begin
            markerErr_d = 1'b1;
          end
        end
        CDB_MD_ACTIVE: begin
          if (isEnd) begin
            state_d     = CDB_MD_IDLE;
            endPulse_d  = 1'b1;
            regionLen_d = cntValue;
          end else if (isStart) begin
            // Nested start: flag it, leave the count alone.
            markerErr_d = 1'b1;
          end else begin
            cntInc = ~cntTc;
`ifdef OR1200_CYPHERDB_MARKER_WATCHDOG_EN
            if (cntValue == WdPreLimit) begin
              state_d     = CDB_MD_IDLE;
              endPulse_d  = 1'b1;
              markerErr_d = 1'b1;
              regionLen_d = MAX_INSN;
            end
`endif
          end
        end
        default: state_d = CDB_MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= CDB_MD_IDLE;
      startPulse_q <= 1'b0;
      endPulse_q   <= 1'b0;
      markerErr_q  <= 1'b0;
      regionLen_q  <= '0;
    end else begin
      state_q      <= state_d;
      startPulse_q <= startPulse_d;
      endPulse_q   <= endPulse_d;
      markerErr_q  <= markerErr_d;
      regionLen_q  <= regionLen_d;
    end
  end

  assign start_pulse_o = startPulse_q;
  assign end_pulse_o   = endPulse_q;
  assign marker_err_o  = markerErr_q;
  assign in_region_o   = (state_q == CDB_MD_ACTIVE);
  assign region_len_o  = regionLen_q;

endmodule

// File: tb/tb_or1200_cypherdb_marker_detect.sv
// ----------------------------------------------------------------------------
// tb_or1200_cypherdb_marker_detect
//
// Directed scenarios followed by randomized EX-stream traffic, all checked
// against a behavioural model of region entry/exit, counting and errors.
// Honours OR1200_CYPHERDB_MARKER_WATCHDOG_EN (watchdog limit 8 when defined).
// ----------------------------------------------------------------------------
module tb_or1200_cypherdb_marker_detect;

  localparam logic [31:0] START_INSN = 32'h150000D0;
  localparam logic [31:0] END_INSN   = 32'h150000D1;
  localparam logic [31:0] ADD_INSN   = 32'hE0621800;
  localparam int          CNT_MAX    = 65535;
  localparam int          WD_MAX     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [31:0] exInsn = 32'h0;
  logic        exValid = 1'b0;
  logic        exFreeze = 1'b0;
  logic        exFlush = 1'b0;
  logic        startPulse, endPulse, inRegion, markerErr;
  logic [15:0] regionLen;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit mActive = 0;
  int mCount = 0;
  int mLen = 0;
  bit eStart = 0, eEnd = 0, eErr = 0;

  always #5 clk = ~clk;

`ifdef OR1200_CYPHERDB_MARKER_WATCHDOG_EN
  or1200_cypherdb_marker_detect #(.MAX_INSN(16'(WD_MAX))) dut (
`else
  or1200_cypherdb_marker_detect dut (
`endif
    .clk_i         (clk),
    .rst_i         (rst),
    .ce_i          (ce),
    .ex_insn_i     (exInsn),
    .ex_valid_i    (exValid),
    .ex_freeze_i   (exFreeze),
    .ex_flush_i    (exFlush),
    .start_pulse_o (startPulse),
    .end_pulse_o   (endPulse),
    .in_region_o   (inRegion),
    .region_len_o  (regionLen),
    .marker_err_o  (markerErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("start_pulse", {31'b0, startPulse}, {31'b0, eStart});
    checkOutput("end_pulse",   {31'b0, endPulse},   {31'b0, eEnd});
    checkOutput("marker_err",  {31'b0, markerErr},  {31'b0, eErr});
    checkOutput("in_region",   {31'b0, inRegion},   {31'b0, mActive});
    checkOutput("region_len",  {16'b0, regionLen},  mLen);
  endtask

  // Model of one clock edge given the inputs presented to it.
  task automatic predict(input logic [31:0] insn, input bit v, input bit f, input bit fl, input bit c);
    bit committed, isS, isE;
    committed = v && !f && !fl;
    isS = (insn[31:24] == 8'h15) && (insn[15:0] == 16'h00D0);
    isE = (insn[31:24] == 8'h15) && (insn[15:0] == 16'h00D1);
    eStart = 0; eEnd = 0; eErr = 0;
    if (!c) begin
      mActive = 0;
      mCount = 0;
    end else if (committed) begin
      if (!mActive) begin
        if (isS) begin mActive = 1; eStart = 1; mCount = 0; end
        else if (isE) eErr = 1;
      end else begin
        if (isE) begin mActive = 0; eEnd = 1; mLen = mCount; end
        else if (isS) eErr = 1;
        else begin
          if (mCount < CNT_MAX) mCount++;
`ifdef OR1200_CYPHERDB_MARKER_WATCHDOG_EN
          if (mCount == WD_MAX) begin
            mActive = 0; eEnd = 1; eErr = 1; mLen = WD_MAX;
          end
`endif
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] insn, input bit v, input bit f, input bit fl, input bit c);
    exInsn = insn; exValid = v; exFreeze = f; exFlush = fl; ce = c;
    predict(insn, v, f, fl, c);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic commitInsn(input logic [31:0] insn);
    applyStimulus(insn, 1, 0, 0, 1);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] insn;
    int holdLeft;

    // Reset values
    #12;
    checkAll();
    checkOutput("reset_in_region", {31'b0, inRegion}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic region: start, 5 ordinary, end
    commitInsn(START_INSN);
    checkOutput("basic_start", {31'b0, startPulse}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      commitInsn(ADD_INSN + i);
      checkOutput("basic_inreg", {31'b0, inRegion}, 32'd1);
    end
    commitInsn(END_INSN);
    checkOutput("basic_end", {31'b0, endPulse}, 32'd1);
    checkOutput("basic_len", {16'b0, regionLen}, 32'd5);
    applyStimulus(32'h0, 0, 0, 0, 1);

    // Frozen start marker produces one pulse after release
    for (int i = 0; i < 4; i++) applyStimulus(START_INSN, 1, 1, 0, 1);
    commitInsn(START_INSN);
    checkOutput("freeze_start", {31'b0, startPulse}, 32'd1);
    applyStimulus(32'h0, 0, 0, 0, 1);
    checkOutput("freeze_single", {31'b0, startPulse}, 32'd0);
    commitInsn(END_INSN);
    checkOutput("freeze_len", {16'b0, regionLen}, 32'd0);

    // Flushed start, then end in IDLE
    applyStimulus(START_INSN, 1, 0, 1, 1);
    checkOutput("flush_inreg", {31'b0, inRegion}, 32'd0);
    commitInsn(END_INSN);
    checkOutput("idle_end_err", {31'b0, markerErr}, 32'd1);
    checkOutput("idle_end_noend", {31'b0, endPulse}, 32'd0);

    // Nested start
    commitInsn(START_INSN);
    commitInsn(ADD_INSN);
    commitInsn(ADD_INSN);
    commitInsn(START_INSN);
    checkOutput("nest_err", {31'b0, markerErr}, 32'd1);
    checkOutput("nest_inreg", {31'b0, inRegion}, 32'd1);
    commitInsn(ADD_INSN);
    commitInsn(END_INSN);
    checkOutput("nest_end", {31'b0, endPulse}, 32'd1);
    checkOutput("nest_len", {16'b0, regionLen}, 32'd3);

    // ce drop while ACTIVE, with an end marker present
    commitInsn(START_INSN);
    commitInsn(ADD_INSN);
    applyStimulus(END_INSN, 1, 0, 0, 0);
    checkOutput("ce_inreg", {31'b0, inRegion}, 32'd0);
    checkOutput("ce_noend", {31'b0, endPulse}, 32'd0);
    checkOutput("ce_len_hold", {16'b0, regionLen}, 32'd3);

    // Asynchronous reset mid-region
    commitInsn(START_INSN);
    commitInsn(ADD_INSN);
    exValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    mActive = 0; mCount = 0; mLen = 0; eStart = 0; eEnd = 0; eErr = 0;
    checkAll();
    checkOutput("arst_inreg", {31'b0, inRegion}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Watchdog boundary
    commitInsn(START_INSN);
    for (int i = 0; i < WD_MAX; i++) commitInsn(ADD_INSN);
`ifdef OR1200_CYPHERDB_MARKER_WATCHDOG_EN
    checkOutput("wd_end", {31'b0, endPulse}, 32'd1);
    checkOutput("wd_err", {31'b0, markerErr}, 32'd1);
    checkOutput("wd_len", {16'b0, regionLen}, WD_MAX);
    // End marker on the limit commit wins over the watchdog
    commitInsn(START_INSN);
    for (int i = 0; i < WD_MAX - 1; i++) commitInsn(ADD_INSN);
    commitInsn(END_INSN);
    checkOutput("wd_endwins_err", {31'b0, markerErr}, 32'd0);
    checkOutput("wd_endwins_len", {16'b0, regionLen}, WD_MAX - 1);
`else
    checkOutput("nowd_active", {31'b0, inRegion}, 32'd1);
    commitInsn(END_INSN);
    checkOutput("nowd_len", {16'b0, regionLen}, WD_MAX);
`endif

    // Randomized traffic
    holdLeft = 0;
    insn = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      bit v, f, fl, c;
      r = $urandom;
      if (holdLeft == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    insn = START_INSN;
          2, 3:    insn = END_INSN;
          4:       insn = {8'h15, r[7:0], 16'h00D0};
          5:       insn = {8'h15, r[7:0], 16'h01D1};
          6:       insn = {8'h14, r[7:0], 16'h00D0};
          default: insn = $urandom;
        endcase
        if ($urandom_range(0, 9) == 0) holdLeft = $urandom_range(2, 6);
      end else begin
        holdLeft--;
      end
      v  = ($urandom_range(0, 99) < 85);
      f  = (holdLeft != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 10);
      c  = ($urandom_range(0, 99) < 97);
      applyStimulus(insn, v, f, fl, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
